// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: wide adder that reuses one SLICE-bit CLA slice, one slice per cycle.
// Optional feature macro: CLA_SUB_EN (adds the sub port and two's-complement subtract).
module cla_slice_sequencer #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NB = SLICE / 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             last;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [SLICE-1:0] a_s, b_s, g, p, c_bit, slice_sum;
    logic [NB-1:0]    bg, bp;
    logic [NB:0]      bc;
    logic             term, acc;
    logic             slice_cout;

`ifdef CLA_SUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? 1'b1 : c_in;
`else
    assign b_in   = b;
    assign cin_in = c_in;
`endif

    assign last       = (idx_q == IW'(N - 1));
    assign a_s        = a_q[idx_q*SLICE +: SLICE];
    assign b_s        = b_q[idx_q*SLICE +: SLICE];
    assign g          = a_s & b_s;
    assign p          = a_s ^ b_s;
    assign slice_sum  = p ^ c_bit;
    assign slice_cout = bc[NB];

    // Group generate/propagate of each 4-bit CLA block
    always_comb begin
        bg = '0;
        bp = '0;
        for (int k = 0; k < NB; k++) begin
            bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bp[k] = &p[4*k +: 4];
        end
    end

    // Lookahead carry unit: every block carry-in is a flat sum of products, no ripple
    always_comb begin
        bc    = '0;
        bc[0] = carry_q;
        term  = 1'b0;
        acc   = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            term = carry_q;
            for (int m = 0; m < k; m++) term = term & bp[m];
            acc = term;
            for (int j = 0; j < k; j++) begin
                term = bg[j];
                for (int m = j + 1; m < k; m++) term = term & bp[m];
                acc = acc | term;
            end
            bc[k] = acc;
        end
    end

    // Bit carries inside each 4-bit block, expanded from the block carry-in
    always_comb begin
        c_bit = '0;
        for (int k = 0; k < NB; k++) begin
            c_bit[4*k]   = bc[k];
            c_bit[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c_bit[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c_bit[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                         | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode from state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: latch operands on accept, write one slice per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b_in;
            carry_d = cin_in;
            idx_d   = '0;
        end
        if (state_q == RUN) begin
            sum_d[idx_q*SLICE +: SLICE] = slice_sum;
            carry_d = slice_cout;
            idx_d   = last ? '0 : idx_q + 1'b1;
            c_out_d = last ? slice_cout : c_out_q;
            ovf_d   = last ? (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE-1] != a_q[WIDTH-1])
                           : ovf_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
endmodule
